// File: rtl/nn_isa_pkg.sv
// NN CPU ISA definitions: opcode and ALU encodings, sequencer states and
// opcode classes, plus the shared opcode classification functions.
package nn_isa_pkg;

  // Opcodes are zero-extended into this width before decoding.
  localparam int OPC_MAX_W = 16;

  localparam logic [OPC_MAX_W-1:0] OP_NOP  = 16'h0000;
  localparam logic [OPC_MAX_W-1:0] OP_ADD  = 16'h0001;
  localparam logic [OPC_MAX_W-1:0] OP_MUL  = 16'h0002;
  localparam logic [OPC_MAX_W-1:0] OP_SLT  = 16'h0003;
  localparam logic [OPC_MAX_W-1:0] OP_MAC  = 16'h0004;
  localparam logic [OPC_MAX_W-1:0] OP_ADDI = 16'h0009;
  localparam logic [OPC_MAX_W-1:0] OP_HALT = 16'h000B;
  localparam logic [OPC_MAX_W-1:0] OP_LD   = 16'h000E;
  localparam logic [OPC_MAX_W-1:0] OP_ST   = 16'h000F;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_MUL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_NONE = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_MULT, C_LOAD, C_STORE, C_HALT, C_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify_op(input logic [OPC_MAX_W-1:0] op);
    op_class_e c;
    case (op)
      OP_NOP:                  c = C_NOP;
      OP_ADD, OP_SLT, OP_ADDI: c = C_ALU;
      OP_MUL, OP_MAC:          c = C_MULT;
      OP_LD:                   c = C_LOAD;
      OP_ST:                   c = C_STORE;
      OP_HALT:                 c = C_HALT;
      default:                 c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  // LD/ST use the stage-1 adder for base+offset address generation.
  function automatic logic [2:0] alu_ctl1_of(input logic [OPC_MAX_W-1:0] op);
    logic [2:0] c;
    case (op)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: c = ALU_ADD;
      OP_MUL, OP_MAC:                c = ALU_MUL;
      OP_SLT:                        c = ALU_SLT;
      default:                       c = ALU_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_ctl2_of(input logic [OPC_MAX_W-1:0] op);
    return (op == OP_MAC) ? ALU_ADD : ALU_NONE;
  endfunction

  function automatic logic alu_src_of(input logic [OPC_MAX_W-1:0] op);
    return op == OP_ADDI;
  endfunction

endpackage

// File: rtl/nn_op_decode.sv
// Combinational decode of the latched opcode into its class and the
// ALU controls used while the instruction is in flight.
module nn_op_decode
  import nn_isa_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int ALU_W = 3
) (
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class,
  output logic [ALU_W-1:0] alu_ctl1,
  output logic [ALU_W-1:0] alu_ctl2,
  output logic             alu_src,
  output logic             legal
);

  logic [OPC_MAX_W-1:0] op_ext;

  always_comb begin
    op_ext   = OPC_MAX_W'(opcode);
    op_class = classify_op(op_ext);
    alu_ctl1 = ALU_W'(alu_ctl1_of(op_ext));
    alu_ctl2 = ALU_W'(alu_ctl2_of(op_ext));
    alu_src  = alu_src_of(op_ext);
    legal    = (op_class != C_ILLEGAL);
  end

endmodule

// File: rtl/nn_ctrl_fsm.sv
// Multi-cycle NN CPU control sequencer: FETCH/EXEC/MEM/WB with stretched
// MUL/MAC, memory handshake, sticky HALT/TRAP and a retired counter.
module nn_ctrl_fsm
  import nn_isa_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int ALU_W   = 3,
  parameter int MAC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPC_W-1:0] opcode,
  output logic             instr_ready,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [ALU_W-1:0] alu_ctl1,
  output logic [ALU_W-1:0] alu_ctl2,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int EW = $clog2(MAC_LAT + 1);
  localparam logic [EW-1:0] CNT_LAST = EW'(MAC_LAT - 1);

  state_e           state_q, state_d;
  logic             run_q;
  logic [OPC_W-1:0] op_q;
  logic [EW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q;

  op_class_e        fetch_cls;
  op_class_e        cls;
  logic [ALU_W-1:0] dec_ctl1, dec_ctl2;
  logic             dec_src, dec_legal;
  logic             take;

  assign fetch_cls = classify_op(OPC_MAX_W'(opcode));
  assign take      = (state_q == S_FETCH) && instr_valid && run_q;
  assign retired   = retired_q;

  nn_op_decode #(.OPC_W(OPC_W), .ALU_W(ALU_W)) u_dec (
    .opcode   (op_q),
    .op_class (cls),
    .alu_ctl1 (dec_ctl1),
    .alu_ctl2 (dec_ctl2),
    .alu_src  (dec_src),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      op_q      <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      if (take) op_q <= opcode;
      if (pc_en) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // ALU controls stay on through MEM/WB so address and result remain stable.
  // A store completes in the same cycle mem_ready arrives, so pc_en there
  // follows mem_ready directly; every other output is a pure state decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    alu_ctl1    = ALU_W'(ALU_NONE);
    alu_ctl2    = ALU_W'(ALU_NONE);
    pc_en       = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = run_q;
        cnt_d       = '0;
        if (take) begin
          case (fetch_cls)
            C_HALT:    state_d = S_HALT;
            C_ILLEGAL: state_d = S_TRAP;
            default:   state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu_ctl1 = dec_ctl1;
        alu_ctl2 = dec_ctl2;
        alu_src  = dec_src;
        if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          case (cls)
            C_NOP: begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
            C_MULT: begin
              if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = S_WB;
              end else begin
                cnt_d = cnt_q + EW'(1);
              end
            end
            C_LOAD, C_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        alu_ctl1  = dec_ctl1;
        alu_ctl2  = dec_ctl2;
        alu_src   = dec_src;
        mem_req   = 1'b1;
        mem_write = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_ctl1   = dec_ctl1;
        alu_ctl2   = dec_ctl2;
        alu_src    = dec_src;
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LOAD);
        pc_en      = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  halted  = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule
